// File: rtl/cpu_dbg_pkg.sv
// -----------------------------------------------------------------------------
// cpu_dbg_pkg
// Shared types and constants for the CPU debug monitor.
//   dbg_state_e : register-sweep FSM state, also exported as a debug output
//   log_entry_t : one memory-write log record {addr, data}
//   REG_W / RA_W / MADDR_W : register data, register address and memory
//                            address widths of the CPU debug interface
// -----------------------------------------------------------------------------
package cpu_dbg_pkg;

  localparam int REG_W   = 16;
  localparam int RA_W    = 4;
  localparam int MADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    REL  = 3'd3,
    NEXT = 3'd4
  } dbg_state_e;

  typedef struct packed {
    logic [MADDR_W-1:0] addr;
    logic [REG_W-1:0]   data;
  } log_entry_t;

endpackage

// File: rtl/dbg_log_fifo.sv
// -----------------------------------------------------------------------------
// dbg_log_fifo
// Parameterized show-ahead FIFO. The head entry is visible on dout whenever
// valid is high; pop consumes it. A push into a full FIFO is dropped and sets
// the sticky overflow flag, unless a pop happens in the same cycle, in which
// case both succeed and count is unchanged. A pop on an empty FIFO is ignored.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, din       : write request and data
//   pop             : consume head entry (ignored when empty)
//   dout, valid     : head entry (zero when empty) and non-empty flag
//   full, count     : full flag and occupancy (0..DEPTH)
//   overflow        : sticky, set when a push is dropped
// DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module dbg_log_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = valid ? mem[rd_ptr] : '0;

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_dbg_monitor.sv
// -----------------------------------------------------------------------------
// cpu_dbg_monitor
// Host-side debug agent for the CPU. Sweeps r0..r(NUM_REGS-1) through the
// CPU regfile peek port into a shadow array that the display reads
// combinationally, and logs CPU data-memory writes into a show-ahead FIFO.
//
// Build option: define DBG_SYNC_EN to pass dbg_regfile_grant and
// dbg_memupdate through 2-flop synchronizers before edge detection (adds
// 2 cycles of detect latency; the CPU must hold rd/memaddr/memdata stable for
// at least 3 cycles). Undefined: edge detection uses the raw inputs.
//
// Regfile handshake: the monitor raises dbg_regfile_request with
// dbg_regfile_ra held stable; the CPU answers by raising dbg_regfile_grant,
// and the rising edge of grant marks dbg_regfile_rd valid in that cycle. The
// monitor then drops request and waits for grant to fall before moving on.
// Either wait gives up after GRANT_TIMEOUT cycles and sets timeout_err.
//
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   SCAN_EN             : level; sweeps repeat back-to-back while high
//   dbg_regfile_*       : request/ra out, grant/rd in (CPU regfile port)
//   dbg_mem*            : memory-write strobe, address, data from the CPU
//   sel_reg/sel_reg_data: display read of the shadow array
//   scan_done           : 1-cycle pulse at the end of each sweep
//   timeout_err         : sticky grant-timeout flag
//   log_*               : memory-write log FIFO head, pop, count, overflow
//   dbg_state           : current sweep FSM state (dbg_state_e encoding)
// -----------------------------------------------------------------------------
module cpu_dbg_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int NUM_REGS      = 16,
  parameter int GRANT_TIMEOUT = 255,
  parameter int LOG_DEPTH     = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         SCAN_EN,
  output logic                         dbg_regfile_request,
  output logic [3:0]                   dbg_regfile_ra,
  input  logic                         dbg_regfile_grant,
  input  logic [15:0]                  dbg_regfile_rd,
  input  logic                         dbg_memupdate,
  input  logic [7:0]                   dbg_memaddr,
  input  logic [15:0]                  dbg_memdata,
  input  logic [3:0]                   sel_reg,
  output logic [15:0]                  sel_reg_data,
  output logic                         scan_done,
  output logic                         timeout_err,
  output logic                         log_valid,
  output logic [7:0]                   log_addr,
  output logic [15:0]                  log_data,
  input  logic                         log_pop,
  output logic [$clog2(LOG_DEPTH):0]   log_count,
  output logic                         log_overflow,
  output logic [2:0]                   dbg_state
);

  localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);
  localparam int LCW   = $clog2(LOG_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [RA_W-1:0]  IDX_LAST = RA_W'(NUM_REGS - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning and edge detection
  // ---------------------------------------------------------------------------
  logic grant_s;
  logic mem_s;
  logic grant_q;
  logic mem_q;
  logic grant_rise;
  logic mem_rise;

`ifdef DBG_SYNC_EN
  logic [1:0] grant_sync;
  logic [1:0] mem_sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_sync <= '0;
      mem_sync   <= '0;
    end else begin
      grant_sync <= {grant_sync[0], dbg_regfile_grant};
      mem_sync   <= {mem_sync[0], dbg_memupdate};
    end
  end

  assign grant_s = grant_sync[1];
  assign mem_s   = mem_sync[1];
`else
  assign grant_s = dbg_regfile_grant;
  assign mem_s   = dbg_memupdate;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_q <= 1'b0;
      mem_q   <= 1'b0;
    end else begin
      grant_q <= grant_s;
      mem_q   <= mem_s;
    end
  end

  assign grant_rise = grant_s & ~grant_q;
  assign mem_rise   = mem_s & ~mem_q;

  // ---------------------------------------------------------------------------
  // Register-sweep FSM
  // ---------------------------------------------------------------------------
  dbg_state_e       state;
  dbg_state_e       state_n;
  logic [RA_W-1:0]  idx;
  logic [RA_W-1:0]  idx_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             set_timeout;
  logic             capture;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      if (set_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n             = state;
    idx_n               = idx;
    cnt_n               = cnt;
    set_timeout         = 1'b0;
    capture             = 1'b0;
    dbg_regfile_request = 1'b0;
    scan_done           = 1'b0;
    case (state)
      IDLE: begin
        if (SCAN_EN) begin
          idx_n   = '0;
          state_n = REQ;
        end
      end
      REQ: begin
        dbg_regfile_request = 1'b1;
        cnt_n               = '0;
        state_n             = WAIT;
      end
      WAIT: begin
        dbg_regfile_request = 1'b1;
        if (grant_rise) begin
          capture = 1'b1;
          cnt_n   = '0;
          state_n = REL;
        end else if (cnt == CNT_LAST) begin
          // Abandon this register; its shadow entry keeps the old value.
          set_timeout = 1'b1;
          cnt_n       = '0;
          state_n     = REL;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      REL: begin
        // Registered grant is used so a grant that rose this very cycle
        // still holds the FSM here until the CPU lets go.
        if (!grant_q) begin
          state_n = NEXT;
        end else if (cnt == CNT_LAST) begin
          set_timeout = 1'b1;
          state_n     = NEXT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      NEXT: begin
        if (idx == IDX_LAST) begin
          scan_done = 1'b1;
          idx_n     = '0;
          state_n   = SCAN_EN ? REQ : IDLE;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = REQ;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // idx only moves in IDLE and NEXT, where request is low, so ra is stable
  // for the whole time request is high.
  assign dbg_regfile_ra = idx;
  assign dbg_state      = state;

  // ---------------------------------------------------------------------------
  // Shadow register array
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0] shadow [NUM_REGS];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else if (capture) begin
      shadow[idx] <= dbg_regfile_rd;
    end
  end

  assign sel_reg_data = (32'(sel_reg) < NUM_REGS) ? shadow[sel_reg] : '0;

  // ---------------------------------------------------------------------------
  // Memory-write log
  // ---------------------------------------------------------------------------
  log_entry_t push_entry;
  log_entry_t head_entry;
  logic       log_full;

  assign push_entry.addr = dbg_memaddr;
  assign push_entry.data = dbg_memdata;

  dbg_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .W     ($bits(log_entry_t))
  ) u_log_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (mem_rise),
    .din      (push_entry),
    .pop      (log_pop),
    .dout     (head_entry),
    .valid    (log_valid),
    .full     (log_full),
    .count    (log_count),
    .overflow (log_overflow)
  );

  assign log_addr = head_entry.addr;
  assign log_data = head_entry.data;

  a_full_count: assert property (@(posedge CLK) disable iff (RST)
    log_full |-> (log_count == LCW'(LOG_DEPTH)));

endmodule

// File: tb/tb_cpu_dbg_monitor.sv
module tb_cpu_dbg_monitor;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SCAN_EN = 1'b0;
  logic        dbg_regfile_request;
  logic [3:0]  dbg_regfile_ra;
  logic        dbg_regfile_grant = 1'b0;
  logic [15:0] dbg_regfile_rd = '0;
  logic        dbg_memupdate = 1'b0;
  logic [7:0]  dbg_memaddr = '0;
  logic [15:0] dbg_memdata = '0;
  logic [3:0]  sel_reg = '0;
  logic [15:0] sel_reg_data;
  logic        scan_done;
  logic        timeout_err;
  logic        log_valid;
  logic [7:0]  log_addr;
  logic [15:0] log_data;
  logic        log_pop = 1'b0;
  logic [3:0]  log_count;
  logic        log_overflow;
  logic [2:0]  dbg_state;

  always #5 CLK = ~CLK;

  cpu_dbg_monitor dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .SCAN_EN             (SCAN_EN),
    .dbg_regfile_request (dbg_regfile_request),
    .dbg_regfile_ra      (dbg_regfile_ra),
    .dbg_regfile_grant   (dbg_regfile_grant),
    .dbg_regfile_rd      (dbg_regfile_rd),
    .dbg_memupdate       (dbg_memupdate),
    .dbg_memaddr         (dbg_memaddr),
    .dbg_memdata         (dbg_memdata),
    .sel_reg             (sel_reg),
    .sel_reg_data        (sel_reg_data),
    .scan_done           (scan_done),
    .timeout_err         (timeout_err),
    .log_valid           (log_valid),
    .log_addr            (log_addr),
    .log_data            (log_data),
    .log_pop             (log_pop),
    .log_count           (log_count),
    .log_overflow        (log_overflow),
    .dbg_state           (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];
  logic [15:0] shadow_exp[16];
  int          scan_cnt = 0;
  int          wait5_cycles = 0;

  // CPU regfile model controls
  logic        block_en = 1'b0;
  logic [3:0]  block_ra = '0;
  logic [15:0] rd_base = 16'hA000;
  int          gdly = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // CPU model: grants 3 cycles after seeing request, drops grant once
  // request falls. A blocked register address is never granted.
  always @(negedge CLK) begin
    if (RST) begin
      dbg_regfile_grant = 1'b0;
      gdly = 0;
    end else if (dbg_regfile_request && !dbg_regfile_grant) begin
      if (!(block_en && dbg_regfile_ra == block_ra)) begin
        gdly++;
        if (gdly == 3) begin
          dbg_regfile_grant = 1'b1;
          dbg_regfile_rd    = rd_base + {12'h000, dbg_regfile_ra};
        end
      end
    end else if (!dbg_regfile_request) begin
      dbg_regfile_grant = 1'b0;
      gdly = 0;
    end
  end

  // Output monitor
  always @(negedge CLK) begin
    if (scan_done) scan_cnt++;
    if (dbg_state == ST_WAIT && dbg_regfile_ra == 4'd5) wait5_cycles++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic pulse_scan();
    @(negedge CLK);
    SCAN_EN = 1'b1;
    @(negedge CLK);
    SCAN_EN = 1'b0;
  endtask

  task automatic wait_scan(input int target, input int budget);
    int n = 0;
    while (scan_cnt < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check_val("scan_wait", 32'(scan_cnt >= target), 32'd1);
  endtask

  task automatic check_shadow(input string tag);
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      sel_reg = k[3:0];
      #1;
      check_val($sformatf("%s[%0d]", tag, k), 32'(sel_reg_data), 32'(shadow_exp[k]));
    end
  endtask

  task automatic mem_event(input logic [7:0] a, input logic [15:0] d, input bit expect_kept);
    @(negedge CLK);
    dbg_memaddr   = a;
    dbg_memdata   = d;
    dbg_memupdate = 1'b1;
    if (expect_kept) exp_q.push_back({a, d});
    @(negedge CLK);
    dbg_memupdate = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [23:0] e;
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      check_val({tag, "_underrun"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_valid"}, 32'(log_valid), 32'd1);
      check_val({tag, "_entry"}, {8'h00, log_addr, log_data}, {8'h00, e});
    end
    log_pop = 1'b1;
    @(negedge CLK);
    log_pop = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #1;
    check_val("rst_request", 32'(dbg_regfile_request), 32'd0);
    check_val("rst_ra", 32'(dbg_regfile_ra), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_val("rst_scan_done", 32'(scan_done), 32'd0);
    check_val("rst_timeout", 32'(timeout_err), 32'd0);
    check_val("rst_log_valid", 32'(log_valid), 32'd0);
    check_val("rst_log_count", 32'(log_count), 32'd0);
    check_val("rst_overflow", 32'(log_overflow), 32'd0);
    check_val("rst_sel_data", 32'(sel_reg_data), 32'd0);

    // Full sweep with prompt grants
    for (int k = 0; k < 16; k++) shadow_exp[k] = 16'hA000 + 16'(k);
    pulse_scan();
    wait_scan(1, 2000);
    repeat (20) @(negedge CLK);
    check_val("sweep_scan_count", 32'(scan_cnt), 32'd1);
    check_val("sweep_idle", 32'(dbg_state), 32'(ST_IDLE));
    check_val("sweep_timeout", 32'(timeout_err), 32'd0);
    check_shadow("sweep_shadow");

    // Sweep with r5 never granted
    rd_base      = 16'hB000;
    block_en     = 1'b1;
    block_ra     = 4'd5;
    wait5_cycles = 0;
    for (int k = 0; k < 16; k++) if (k != 5) shadow_exp[k] = 16'hB000 + 16'(k);
    pulse_scan();
    wait_scan(2, 3000);
    repeat (5) @(negedge CLK);
    check_val("to_scan_count", 32'(scan_cnt), 32'd2);
    check_val("to_timeout_err", 32'(timeout_err), 32'd1);
    check_val("to_wait_cycles", 32'(wait5_cycles), 32'd255);
    check_shadow("to_shadow");
    block_en = 1'b0;

    // Log push and ordered drain
    mem_event(8'h10, 16'h1111, 1'b1);
    mem_event(8'h11, 16'h2222, 1'b1);
    mem_event(8'h12, 16'h3333, 1'b1);
    @(negedge CLK);
    check_val("log3_count", 32'(log_count), 32'd3);
    check_val("log3_head", {8'h00, log_addr, log_data}, {8'h00, 8'h10, 16'h1111});
    while (exp_q.size() > 0) pop_check("log3_pop");
    @(negedge CLK);
    check_val("log3_empty", 32'(log_valid), 32'd0);
    // Pop on empty is ignored
    log_pop = 1'b1;
    @(negedge CLK);
    log_pop = 1'b0;
    check_val("empty_pop_count", 32'(log_count), 32'd0);

    // Overflow: nine events, ninth dropped
    for (int i = 0; i < 9; i++) mem_event(8'h20 + 8'(i), 16'h5000 + 16'(i), i < 8);
    @(negedge CLK);
    check_val("ovf_count", 32'(log_count), 32'd8);
    check_val("ovf_flag", 32'(log_overflow), 32'd1);
    check_val("ovf_head", {8'h00, log_addr, log_data}, {8'h00, exp_q[0]});
    // Simultaneous push and pop while full
    dbg_memaddr   = 8'h99;
    dbg_memdata   = 16'h9999;
    dbg_memupdate = 1'b1;
    log_pop       = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back({8'h99, 16'h9999});
    @(negedge CLK);
    dbg_memupdate = 1'b0;
    log_pop       = 1'b0;
    check_val("pp_count", 32'(log_count), 32'd8);
    check_val("pp_ovf_sticky", 32'(log_overflow), 32'd1);
    while (exp_q.size() > 0) pop_check("ovf_pop");
    @(negedge CLK);
    check_val("ovf_drained", 32'(log_valid), 32'd0);

    // Held memupdate gives exactly one entry
    @(negedge CLK);
    dbg_memaddr   = 8'h77;
    dbg_memdata   = 16'h7777;
    dbg_memupdate = 1'b1;
    exp_q.push_back({8'h77, 16'h7777});
    repeat (5) @(negedge CLK);
    dbg_memupdate = 1'b0;
    @(negedge CLK);
    check_val("held_count", 32'(log_count), 32'd1);
    pop_check("held_pop");

    // Reset while waiting on r7
    block_en = 1'b1;
    block_ra = 4'd7;
    pulse_scan();
    n = 0;
    while (!(dbg_state == ST_WAIT && dbg_regfile_ra == 4'd7) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check_val("rw_reached", 32'(dbg_state == ST_WAIT && dbg_regfile_ra == 4'd7), 32'd1);
    mem_event(8'h55, 16'h5555, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    check_val("rw_request", 32'(dbg_regfile_request), 32'd0);
    check_val("rw_state", 32'(dbg_state), 32'(ST_IDLE));
    check_val("rw_timeout", 32'(timeout_err), 32'd0);
    check_val("rw_count", 32'(log_count), 32'd0);
    RST      = 1'b0;
    block_en = 1'b0;
    for (int k = 0; k < 16; k++) shadow_exp[k] = 16'h0000;
    check_shadow("rw_shadow");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
